key_expander: RTL and testbench
===============================

# key_expander

Sequential AES-128 key expansion unit. Loads a 128-bit cipher key on a start pulse, produces one round key per clock (rounds 1..10, FIPS-197 forward schedule) into an 11-entry internal key bank, then signals completion. It sits directly upstream of the round datapath and the per-round key consumers, which read any round key through an indexed, registered read port.

## Interface
- No parameters; fixed AES-128: 128-bit key, 11 round keys, 4-bit round index.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to expand key_in; honoured only in IDLE or READY.
- key_in  input  128  cipher key; sampled only on the accepted start edge; bits [127:96] = w0 (FIPS byte 0 at the MSB).
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when round key 10 has been written.
- keys_valid  output  1  level; bank holds a complete schedule for the last accepted key.
- rd_idx  input  4  round key index to read (0..10).
- rd_key  output  128  registered read data for rd_idx; 0 if rd_idx > 10.

## Operation
- FSM states: IDLE, EXPAND, READY.
  - IDLE --start--> EXPAND.
  - EXPAND -> READY after round 10 is written.
  - READY --start--> EXPAND.
  - start in EXPAND is ignored, with no queueing.
- Accepted start:
  - bank[0] <= key_in; round counter r <= 1.
  - keys_valid <= 0.
- Each EXPAND cycle:
  - bank[r] <= next(bank[r-1], Rcon[r]); r increments.
  - After r = 10, r stops and the FSM enters READY.
- next(): split the previous key into words w0..w3 (w0 = [127:96]).
  - t = SubWord(RotWord(w3)) xor {Rcon, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Four combinational FIPS-197 S-box lookups.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Read port:
  - rd_key <= (rd_idx <= 10) ? bank[rd_idx] : 0, every cycle regardless of state.
  - Reads during EXPAND are legal and return current bank contents, which may be stale or zero. Consumers must gate on keys_valid.
- Reset, including mid-expansion:
  - State IDLE, r = 0, all bank entries 0.
  - busy = 0, done = 0, keys_valid = 0, rd_key = 0.
  - A partial schedule is discarded; a fresh start is required.

## Timing
- Start sampled at edge T0:
  - bank[0] is written at T0.
  - bank[k] is written at edge Tk, k = 1..10.
- busy is high in the cycles after T0 through T10 (exactly 10 cycles). It is low in IDLE and READY.
- done is high for exactly one cycle, the cycle after T10, i.e. 10 cycles after start was sampled. keys_valid rises in the same cycle and stays high until the next accepted start or rst.
- A start coincident with the done cycle (state READY) is accepted:
  - keys_valid drops after that edge.
  - done still pulses for that one cycle only.
- Read latency: rd_key reflects rd_idx one edge after rd_idx is presented.
  - A bank entry written at edge Tk is visible on rd_key after edge Tk+1 if rd_idx = k is held.
- No combinational path from any input to any output.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - done exactly 10 cycles after start; busy high for 10 cycles.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 3 = 3d80477d4716fe3e1e237e446d7a883b.
  - Round 4 = ef44a541a8525b7fb671253bdb0bad00.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Round 0 = key.
- All-zero key:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Start pulsed again at cycles 3 and 7 of an expansion -> ignored; done still at cycle 10; FIPS round 10 value intact.
- Assert rst at cycle 5 of an expansion -> all outputs 0 immediately (asynchronously); rd_idx = 1 reads 0.
  - A new start with the zero key then yields the zero-key schedule.
- After FIPS expansion completes:
  - rd_idx = 11 and rd_idx = 15 -> rd_key = 0.
  - rd_idx = 10 -> d014f9a8... one cycle later.
  - Restart from READY with the zero key -> keys_valid low for 10 cycles, then the zero-key round 10 is read.

Source files
------------

// File: rtl/key_expander.sv
// key_expander: sequential AES-128 key schedule into an 11-entry bank with a registered read port.
// One round key per clock; S-boxes are computed as GF(2^8) inverse plus affine map.
module key_expander (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t       state_q;
  logic [3:0]   r_q;
  logic [7:0]   rcon_q;
  logic [127:0] prev_q;
  logic [127:0] bank_q [0:10];
  logic         busy_q, done_q, valid_q;
  logic [127:0] rd_key_q;
  logic [31:0]  w3, t, n0, n1, n2, n3;
  logic [127:0] nxt;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign w3  = prev_q[31:0];
  assign t   = {sbox(w3[23:16]) ^ rcon_q, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0  = prev_q[127:96] ^ t;
  assign n1  = prev_q[95:64] ^ n0;
  assign n2  = prev_q[63:32] ^ n1;
  assign n3  = w3 ^ n2;
  assign nxt = {n0, n1, n2, n3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= 4'd0;
      rcon_q   <= 8'h00;
      prev_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_key_q <= '0;
      for (int i = 0; i < 11; i++) bank_q[i] <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_key_q <= (rd_idx <= 4'd10) ? bank_q[rd_idx] : '0;
      if (start && state_q != EXPAND) begin
        state_q   <= EXPAND;
        bank_q[0] <= key_in;
        prev_q    <= key_in;
        r_q       <= 4'd1;
        rcon_q    <= 8'h01;
        busy_q    <= 1'b1;
        valid_q   <= 1'b0;
      end else if (state_q == EXPAND) begin
        bank_q[r_q] <= nxt;
        prev_q      <= nxt;
        rcon_q      <= xtime(rcon_q);
        if (r_q == 4'd10) begin
          state_q <= READY;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end else begin
          r_q <= r_q + 4'd1;
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = valid_q;
  assign rd_key     = rd_key_q;
endmodule

// File: tb/tb_key_expander.sv
// tb_key_expander: directed checks of the AES-128 key expander against FIPS-197 and all-zero key schedules.
module tb_key_expander;
  logic         clk = 1'b0;
  logic         rst, start, busy, done, keys_valid;
  logic [127:0] key_in, rd_key;
  logic [3:0]   rd_idx;
  int           compared = 0, mismatched = 0;
  int           edges, nbusy, nvlow;
  logic [127:0] sb [$];

  localparam logic [127:0] FK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FR2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FR3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] FR4  = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [127:0] FR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZR1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_expander dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy), .done(done),
    .keys_valid(keys_valid), .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    sb.push_back(exp);
    rd_idx = idx;
    @(posedge clk); #1;
    chk(tag, rd_key, sb.pop_front());
  endtask

  // Returns in the done cycle (or after the bound expires, leaving e far from 10).
  task automatic run_expand(input logic [127:0] k, input int ign_a, input int ign_b,
                            output int e, output int nb, output int nv);
    key_in = k;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0; nb = 0; nv = 0;
    while (!done && e < 40) begin
      nb += int'(busy);
      nv += int'(!keys_valid);
      start = (e == ign_a || e == ign_b);
      key_in = ~k;
      @(posedge clk); #1;
      e++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_in = '0; rd_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_valid", {127'd0, keys_valid}, 128'd0);
    chk("reset_rdkey", rd_key, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_expand(FK, -1, -1, edges, nbusy, nvlow);
    chk("fips_done_lat", 128'(edges), 128'd10);
    chk("fips_busy_cycles", 128'(nbusy), 128'd10);
    chk("fips_valid_low", 128'(nvlow), 128'd10);
    chk("fips_valid_at_done", {127'd0, keys_valid}, 128'd1);
    chk("fips_busy_at_done", {127'd0, busy}, 128'd0);
    rd(4'd0, FK, "fips_r0");
    chk("done_one_cycle", {127'd0, done}, 128'd0);
    rd(4'd1, FR1, "fips_r1");
    rd(4'd2, FR2, "fips_r2");
    rd(4'd3, FR3, "fips_r3");
    rd(4'd4, FR4, "fips_r4");
    rd(4'd10, FR10, "fips_r10");
    rd(4'd11, 128'd0, "rd_idx11");
    rd(4'd15, 128'd0, "rd_idx15");
    chk("valid_held", {127'd0, keys_valid}, 128'd1);

    run_expand(FK, 3, 7, edges, nbusy, nvlow);
    chk("ign_done_lat", 128'(edges), 128'd10);
    chk("ign_busy_cycles", 128'(nbusy), 128'd10);
    rd(4'd10, FR10, "ign_r10");
    rd(4'd0, FK, "ign_r0");

    run_expand(128'd0, -1, -1, edges, nbusy, nvlow);
    chk("zero_done_lat", 128'(edges), 128'd10);
    chk("zero_valid_low", 128'(nvlow), 128'd10);
    rd(4'd10, ZR10, "zero_r10");
    rd(4'd1, ZR1, "zero_r1");

    // back-to-back: second start lands in the done cycle
    run_expand(FK, -1, -1, edges, nbusy, nvlow);
    chk("b2b_first_lat", 128'(edges), 128'd10);
    run_expand(128'd0, -1, -1, edges, nbusy, nvlow);
    chk("b2b_second_lat", 128'(edges), 128'd10);
    chk("b2b_valid_low", 128'(nvlow), 128'd10);
    rd(4'd10, ZR10, "b2b_r10");

    key_in = FK;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", {127'd0, busy}, 128'd0);
    chk("arst_done", {127'd0, done}, 128'd0);
    chk("arst_valid", {127'd0, keys_valid}, 128'd0);
    chk("arst_rdkey", rd_key, 128'd0);
    #2;
    rst = 1'b0;
    rd(4'd1, 128'd0, "arst_r1_cleared");
    rd(4'd0, 128'd0, "arst_r0_cleared");
    chk("arst_idle_busy", {127'd0, busy}, 128'd0);
    run_expand(128'd0, -1, -1, edges, nbusy, nvlow);
    chk("post_rst_lat", 128'(edges), 128'd10);
    rd(4'd10, ZR10, "post_rst_r10");
    rd(4'd1, ZR1, "post_rst_r1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
